// File: rtl/tdm_pkg.sv
// Shared constants, FSM state type and slot arithmetic for the 4-channel TDM demultiplexer.
package tdm_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SLOT_W = 2;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // Slot after s; relies on SLOT_W-bit wrap so 3 rolls over to 0.
  function automatic logic [SLOT_W-1:0] next_slot(input logic [SLOT_W-1:0] s);
    return s + SLOT_W'(1);
  endfunction

endpackage

// File: rtl/tdm_hold_reg.sv
// One channel holding register: a data word plus valid flag, loaded from the link and drained by the consumer.
module tdm_hold_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             free_c
);

  // A full register that is being drained this cycle can take a new word.
  assign free_c = !valid || ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      data  <= din;
      valid <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/tdm_demux4.sv
// Receive end of the 4:1 TDM link: frame-alignment FSM, slot counter and per-channel steering.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [WIDTH-1:0]        in_data,
  input  logic                    in_sync,
  output logic                    in_ready,
  output logic [NUM_CH*WIDTH-1:0] out_data,
  output logic [NUM_CH-1:0]       out_valid,
  input  logic [NUM_CH-1:0]       out_ready,
  output logic [SLOT_W-1:0]       slot,
  output logic                    locked,
  output logic                    sync_err
);

  state_e              state_q;
  state_e              state_d;
  logic [SLOT_W-1:0]   slot_d;
  logic [SLOT_W-1:0]   tgt_c;
  logic                sync_err_d;
  logic [NUM_CH-1:0]   free_c;
  logic [NUM_CH-1:0]   load_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= HUNT;
      slot     <= '0;
      sync_err <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot     <= slot_d;
      sync_err <= sync_err_d;
    end
  end

  // in_ready never looks at in_valid, so no valid->ready combinational path exists.
  always_comb begin
    state_d    = state_q;
    slot_d     = slot;
    sync_err_d = 1'b0;
    in_ready   = 1'b0;
    load_c     = '0;
    tgt_c      = in_sync ? '0 : slot;
    case (state_q)
      HUNT: begin
        in_ready = in_sync ? free_c[0] : 1'b1;
        if (in_valid && in_ready && in_sync) begin
          load_c[0] = 1'b1;
          slot_d    = next_slot(SLOT_W'(0));
          state_d   = LOCKED;
        end
      end
      LOCKED: begin
        in_ready = free_c[tgt_c];
        if (in_valid && in_ready) begin
          load_c[tgt_c] = 1'b1;
          slot_d        = next_slot(tgt_c);
          sync_err_d    = in_sync && (slot != '0);
        end
      end
      default: state_d = HUNT;
    endcase
  end

  assign locked = (state_q == LOCKED);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    tdm_hold_reg #(
      .WIDTH (WIDTH)
    ) u_hold (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (load_c[c]),
      .din    (in_data),
      .ready  (out_ready[c]),
      .data   (out_data[c*WIDTH +: WIDTH]),
      .valid  (out_valid[c]),
      .free_c (free_c[c])
    );
  end

endmodule

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4: directed vector table, randomized frames against a reference model, reset mid-frame.
module tb_tdm_demux4;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_sync;
  logic        in_ready;
  logic [31:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [1:0]  slot;
  logic        locked;
  logic        sync_err;

  tdm_demux4 #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_sync   (in_sync),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .slot      (slot),
    .locked    (locked),
    .sync_err  (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       s;
    logic [3:0] r;
    logic       e_rdy;
    logic [3:0] e_valid;
    logic [1:0] e_slot;
    logic       e_locked;
    logic       e_err;
    int         e_ch;
    logic [7:0] e_data;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [7:0] d, input logic s, input logic [3:0] r,
                              input logic e_rdy, input logic [3:0] e_valid, input logic [1:0] e_slot,
                              input logic e_locked, input logic e_err, input int e_ch, input logic [7:0] e_data);
    vec_t t;
    t.v = v; t.d = d; t.s = s; t.r = r;
    t.e_rdy = e_rdy; t.e_valid = e_valid; t.e_slot = e_slot;
    t.e_locked = e_locked; t.e_err = e_err; t.e_ch = e_ch; t.e_data = e_data;
    return t;
  endfunction

  // Reference model: channel contents, next slot and lock flag as plain arrays/ints.
  bit         m_valid [4];
  logic [7:0] m_data  [4];
  int         m_slot;
  bit         m_locked;
  bit         m_err;
  logic [7:0] exp_seq [4][256];
  int         exp_n   [4];
  int         obs_n   [4];

  function automatic void model_reset();
    for (int c = 0; c < 4; c++) begin
      m_valid[c] = 0; m_data[c] = 8'h00; exp_n[c] = 0; obs_n[c] = 0;
    end
    m_slot = 0; m_locked = 0; m_err = 0;
  endfunction

  function automatic bit m_free(input int c, input logic [3:0] r);
    return !m_valid[c] || r[c];
  endfunction

  function automatic bit m_ready(input logic s, input logic [3:0] r);
    if (!m_locked) return s ? m_free(0, r) : 1'b1;
    return m_free(s ? 0 : m_slot, r);
  endfunction

  // One cycle: drive at negedge, check ready and drained words before the edge, state after it.
  task automatic step(input logic v, input logic [7:0] d, input logic s, input logic [3:0] r, output bit acc);
    int  tgt;
    bit  ld;
    @(negedge clk);
    in_valid = v; in_data = d; in_sync = s; out_ready = r;
    #1;
    chk("in_ready", 32'(in_ready), 32'(m_ready(s, r)));
    for (int c = 0; c < 4; c++) begin
      if (out_valid[c] && r[c]) begin
        if (obs_n[c] < exp_n[c] && obs_n[c] < 256)
          chk($sformatf("drain_ch%0d", c), 32'(out_data[c*8 +: 8]), 32'(exp_seq[c][obs_n[c]]));
        else
          chk($sformatf("extra_drain_ch%0d", c), 32'(obs_n[c]), 32'(exp_n[c]));
        obs_n[c]++;
      end
    end
    acc = v && m_ready(s, r);
    tgt = s ? 0 : m_slot;
    ld  = acc && (m_locked || s);
    @(posedge clk);
    m_err = ld && m_locked && s && (m_slot != 0);
    for (int c = 0; c < 4; c++) begin
      if (ld && c == tgt) begin
        m_valid[c] = 1; m_data[c] = d;
        if (exp_n[c] < 256) exp_seq[c][exp_n[c]] = d;
        exp_n[c]++;
      end else if (m_valid[c] && r[c]) begin
        m_valid[c] = 0;
      end
    end
    if (ld) begin
      m_slot = (tgt + 1) % 4;
      m_locked = 1;
    end
    #1;
    chk("out_valid", 32'(out_valid), 32'({m_valid[3], m_valid[2], m_valid[1], m_valid[0]}));
    chk("slot", 32'(slot), 32'(m_slot));
    chk("locked", 32'(locked), 32'(m_locked));
    chk("sync_err", 32'(sync_err), 32'(m_err));
    for (int c = 0; c < 4; c++)
      if (m_valid[c]) chk($sformatf("data_ch%0d", c), 32'(out_data[c*8 +: 8]), 32'(m_data[c]));
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'h0);
    chk({tag, "_out_data"}, out_data, 32'h0);
    chk({tag, "_slot"}, 32'(slot), 32'h0);
    chk({tag, "_locked"}, 32'(locked), 32'h0);
    chk({tag, "_sync_err"}, 32'(sync_err), 32'h0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'h1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    model_reset();
    check_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t vt [17];

  initial begin
    bit acc;
    int accepted;
    int cycles;
    bit have;
    logic [7:0] wd;
    logic ws;

    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_sync = 1'b0; out_ready = 4'h0;
    model_reset();
    #12;
    check_reset_state("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table: HUNT discard, first frame, sync realign, blocked target.
    vt[0]  = mk(1, 8'h11, 0, 4'hF, 1, 4'b0000, 2'd0, 0, 0, 4, 8'h00);
    vt[1]  = mk(1, 8'h22, 0, 4'hF, 1, 4'b0000, 2'd0, 0, 0, 4, 8'h00);
    vt[2]  = mk(1, 8'hA0, 1, 4'hF, 1, 4'b0001, 2'd1, 1, 0, 0, 8'hA0);
    vt[3]  = mk(1, 8'hA1, 0, 4'hF, 1, 4'b0010, 2'd2, 1, 0, 1, 8'hA1);
    vt[4]  = mk(1, 8'hA2, 0, 4'hF, 1, 4'b0100, 2'd3, 1, 0, 2, 8'hA2);
    vt[5]  = mk(1, 8'hA3, 0, 4'hF, 1, 4'b1000, 2'd0, 1, 0, 3, 8'hA3);
    vt[6]  = mk(1, 8'hB0, 1, 4'hF, 1, 4'b0001, 2'd1, 1, 0, 0, 8'hB0);
    vt[7]  = mk(1, 8'hB1, 0, 4'hF, 1, 4'b0010, 2'd2, 1, 0, 1, 8'hB1);
    vt[8]  = mk(1, 8'h55, 1, 4'hF, 1, 4'b0001, 2'd1, 1, 1, 0, 8'h55);
    vt[9]  = mk(0, 8'h00, 0, 4'hF, 1, 4'b0000, 2'd1, 1, 0, 4, 8'h00);
    vt[10] = mk(1, 8'hC1, 0, 4'hD, 1, 4'b0010, 2'd2, 1, 0, 1, 8'hC1);
    vt[11] = mk(1, 8'hC2, 0, 4'hD, 1, 4'b0110, 2'd3, 1, 0, 2, 8'hC2);
    vt[12] = mk(1, 8'hC3, 0, 4'hD, 1, 4'b1010, 2'd0, 1, 0, 3, 8'hC3);
    vt[13] = mk(1, 8'hD0, 0, 4'hD, 1, 4'b0011, 2'd1, 1, 0, 0, 8'hD0);
    vt[14] = mk(1, 8'hD1, 0, 4'hD, 0, 4'b0010, 2'd1, 1, 0, 1, 8'hC1);
    vt[15] = mk(1, 8'hD1, 0, 4'hF, 1, 4'b0010, 2'd2, 1, 0, 1, 8'hD1);
    vt[16] = mk(0, 8'h00, 0, 4'hF, 1, 4'b0000, 2'd2, 1, 0, 4, 8'h00);

    foreach (vt[i]) begin
      @(negedge clk);
      in_valid = vt[i].v; in_data = vt[i].d; in_sync = vt[i].s; out_ready = vt[i].r;
      #1;
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vt[i].e_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vt[i].e_valid));
      chk($sformatf("v%0d_slot", i), 32'(slot), 32'(vt[i].e_slot));
      chk($sformatf("v%0d_locked", i), 32'(locked), 32'(vt[i].e_locked));
      chk($sformatf("v%0d_sync_err", i), 32'(sync_err), 32'(vt[i].e_err));
      if (vt[i].e_ch < 4)
        chk($sformatf("v%0d_data", i), 32'(out_data[vt[i].e_ch*8 +: 8]), 32'(vt[i].e_data));
    end

    // Randomized back-to-back frames with random consumer backpressure.
    do_reset();
    accepted = 0; cycles = 0; have = 0; wd = 8'h00; ws = 1'b0;
    while (accepted < 64 && cycles < 3000) begin
      if (!have) begin
        wd = 8'($urandom);
        ws = (m_slot == 0) || ($urandom_range(0, 15) == 0);
        have = ($urandom_range(0, 3) != 0);
      end
      step(have, wd, ws, 4'($urandom), acc);
      if (acc) begin
        accepted++;
        have = 0;
      end
      cycles++;
    end
    chk("random_accept_budget", 32'(accepted), 32'd64);
    for (int k = 0; k < 3; k++) step(0, 8'h00, 0, 4'hF, acc);
    for (int c = 0; c < 4; c++)
      chk($sformatf("stream_len_ch%0d", c), 32'(obs_n[c]), 32'(exp_n[c]));

    // Fill all channels, then reset asynchronously mid-cycle.
    step(1, 8'hE0, 1, 4'h0, acc);
    step(1, 8'hE1, 0, 4'h0, acc);
    step(1, 8'hE2, 0, 4'h0, acc);
    step(1, 8'hE3, 0, 4'h0, acc);
    chk("prereset_full", 32'(out_valid), 32'hF);
    @(negedge clk);
    in_valid = 1'b0; in_sync = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_state("midframe");
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 8'h77, 0, 4'hF, acc);
    step(1, 8'h78, 0, 4'hF, acc);
    chk("post_reset_discard", 32'(out_valid), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
